// File: rtl/fft_input_sequencer.sv
// fft_input_sequencer: collects 16 serial samples, then replays them in base-4 digit-reversed order for a radix-4 FFT.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready          : natural-order sample stream (accepted only while loading)
//   out_data/out_sel/out_group/out_valid/out_ready : reordered sample with demux lane and butterfly group
//   frame_done           : one-cycle pulse after the last sample of a frame is delivered
module fft_input_sequencer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [1:0]           out_sel,
  output logic [1:0]           out_group,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_done
);
  typedef enum logic {LOAD, DRAIN} state_t;
  state_t r_state, w_next;
  logic [WORD_SIZE-1:0] r_buf [16];
  logic [3:0] r_wr_cnt, r_rd_cnt;
  logic r_frame_done, w_in_hs, w_out_hs;
  always_comb begin
    in_ready  = r_state == LOAD;
    out_valid = r_state == DRAIN;
    w_in_hs   = in_valid && in_ready;
    w_out_hs  = out_valid && out_ready;
    w_next    = r_state;
    if (w_in_hs && r_wr_cnt == 4'd15) w_next = DRAIN;
    if (w_out_hs && r_rd_cnt == 4'd15) w_next = LOAD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_wr_cnt     <= 4'd0;
      r_rd_cnt     <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= w_out_hs && r_rd_cnt == 4'd15;
      if (w_in_hs) r_wr_cnt <= r_wr_cnt + 4'd1;
      if (w_out_hs) r_rd_cnt <= r_rd_cnt + 4'd1;
    end
  end
  // Sample storage is deliberately unreset; a full LOAD always precedes any read.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_wr_cnt] <= in_data;
  end
  // Swapping the two base-4 digits of rd_cnt gives the radix-4 input order.
  assign out_data   = r_buf[{r_rd_cnt[1:0], r_rd_cnt[3:2]}];
  assign out_sel    = r_rd_cnt[1:0];
  assign out_group  = r_rd_cnt[3:2];
  assign frame_done = r_frame_done;
endmodule
